bcd2bin: RTL
============

Name: bcd2bin

Overview:
- Sequential converter from signed 4-digit BCD (sign + digits) to sign-magnitude binary.
- Inverse companion of the bin2bcd path: it turns display/keypad-style BCD values back into a binary magnitude for the arithmetic datapath.
- Processes one digit per clock using an iterative multiply-by-10-and-add.
- Flags invalid digits and magnitude overflow, and uses a single-request valid/busy handshake.

Parameters:
DIGITS, 4, number of BCD digits in the input word
MAG_W, 10, output magnitude width (maximum representable value 2^MAG_W-1 = 1023)
ACC_W, 14, accumulator width; must hold 10^DIGITS-1 (9999)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bcd  input  4*DIGITS+1  bit[16] = sign (1 = negative); [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
bcd_vld  input  1  request strobe; sampled only while busy = 0
busy  output  1  high while a conversion is in progress
bin  output  MAG_W+1  bit[10] = sign, [9:0] = magnitude
bin_vld  output  1  one-cycle pulse; bin, bin_err and bin_ovf are valid in that cycle
bin_err  output  1  at least one input nibble was greater than 9
bin_ovf  output  1  decoded magnitude exceeded 2^MAG_W-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state = IDLE; bin, bin_vld, bin_err, bin_ovf, busy all 0; accumulator, digit counter and captured word all 0.
- States: IDLE, ACC, DONE. busy = (state != IDLE).
- IDLE:
  - When bcd_vld = 1 on a rising edge, capture the bcd word.
  - Latch err = OR over all nibbles of (nibble > 9).
  - Clear acc; set cnt = DIGITS-1; go to ACC.
  - With bcd_vld = 0, stay in IDLE.
- ACC, one cycle per digit, most significant digit first:
  - acc <= (acc<<3) + (acc<<1) + digit[cnt], computed ACC_W bits wide, no truncation.
  - When cnt = 0, load the output registers and go to DONE; otherwise decrement cnt.
- Output load (edge leaving the last ACC cycle):
  - If err: bin = 0, bin_err = 1, bin_ovf = 0.
  - Else if acc > 2^MAG_W-1: magnitude saturates to 1023, bin_ovf = 1, sign passes through.
  - Else: magnitude = acc[MAG_W-1:0], bin_ovf = 0.
  - Zero magnitude forces sign = 0 (no negative zero).
  - bin_vld <= 1.
- DONE:
  - bin_vld is high for exactly this one cycle, then cleared.
  - Go to IDLE.
- Latency: capture edge at the end of cycle T, ACC in cycles T+1 to T+4, bin_vld high in cycle T+5. Earliest next capture is at the end of cycle T+6, where busy = 0.
- bcd_vld while busy = 1: ignored, no queueing, the in-flight result is unaffected. The bench must not rely on dropped requests.
- Output hold:
  - bin, bin_err and bin_ovf hold their last result until the next output load.
  - They are not cleared when a new request is accepted.
- Reset mid-conversion: all state clears immediately. No bin_vld is produced for the aborted request.
- The bcd input may change after the capture edge; the conversion uses only the captured copy.

Test Plan:
- {0,1,2,3,4} (+1234) -> bin_vld 5 cycles after capture; bin = {0,10'd1023}, bin_ovf = 1, bin_err = 0.
- {1,0,9,8,7} (-987) -> bin = {1,10'd987}, bin_ovf = 0, bin_err = 0; bin_vld high exactly one cycle.
- {1,0,0,0,0} (-0) -> bin = 11'd0 with sign 0; then {0,9,9,9,9} -> bin = {0,1023}, bin_ovf = 1.
- {0,0,1,A,3} (invalid tens digit) -> bin = 0, bin_err = 1; the next valid request +0042 -> bin = 42, bin_err = 0.
- Back-to-back requests: second bcd_vld pulse at T+2 with a different value -> ignored, only one bin_vld; request at T+6 -> accepted, second bin_vld at T+11.
- rst_n asserted at T+3 of a conversion -> busy, bin and bin_vld go to 0 asynchronously; no bin_vld follows; the next request converts normally.

Source files
------------

// File: rtl/bcd2bin_if.sv
// ----------------------------------------------------------------------------
// bcd2bin_if
// Request/result bundle for the BCD-to-binary converter.
//   bcd      : {sign, DIGITS x 4-bit BCD}, sign = 1 means negative
//   bcd_vld  : request strobe, sampled only while busy = 0
//   busy     : conversion in progress
//   bin      : {sign, MAG_W-bit magnitude}
//   bin_vld  : one-cycle result strobe
//   bin_err  : at least one nibble of the request was above 9
//   bin_ovf  : magnitude saturated at 2^MAG_W-1
// master = requester side, slave = converter side.
// ----------------------------------------------------------------------------
interface bcd2bin_if #(
   parameter int DIGITS = 4,
   parameter int MAG_W  = 10
);
   logic [4*DIGITS:0] bcd;
   logic              bcd_vld;
   logic              busy;
   logic [MAG_W:0]    bin;
   logic              bin_vld;
   logic              bin_err;
   logic              bin_ovf;

   modport master (
      output bcd, bcd_vld,
      input  busy, bin, bin_vld, bin_err, bin_ovf
   );

   modport slave (
      input  bcd, bcd_vld,
      output busy, bin, bin_vld, bin_err, bin_ovf
   );
endinterface

// File: rtl/bcd2bin.sv
// ----------------------------------------------------------------------------
// bcd2bin
// Sequential signed BCD to sign-magnitude binary converter. One digit is
// folded in per clock (acc = acc*10 + digit, most significant digit first).
// Invalid nibbles (> 9) force a zero result with bin_err; magnitudes above
// 2^MAG_W-1 saturate with bin_ovf. Requests arriving while busy are dropped.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd2bin_if slave modport (request in, result out)
// ----------------------------------------------------------------------------
module bcd2bin #(
   parameter int DIGITS = 4,
   parameter int MAG_W  = 10,
   parameter int ACC_W  = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   bcd2bin_if.slave   bus
);
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCD_W = 4 * DIGITS + 1;
   localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << MAG_W) - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [BCD_W-1:0]   word_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;
   logic               busy_q;
   logic [MAG_W:0]     bin_q;
   logic               bin_vld_q;
   logic               bin_err_q;
   logic               bin_ovf_q;

   logic [3:0]         digit_d;
   logic [ACC_W-1:0]   acc_d;
   logic [MAG_W-1:0]   mag_d;
   logic               ovf_d;
   logic               sign_d;

   // True when any BCD nibble of the word lies outside 0..9.
   function automatic logic has_bad_digit(input logic [BCD_W-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | (w[4*i +: 4] > 4'd9);
      end
      return bad;
   endfunction

   // Next accumulator value and the saturated/sign-corrected result it implies.
   always_comb begin
      digit_d = word_q[{cnt_q, 2'b00} +: 4];
      acc_d   = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, digit_d};
      if (err_q) begin
         mag_d = {MAG_W{1'b0}};
         ovf_d = 1'b0;
      end else if (acc_d > MAG_MAX) begin
         mag_d = {MAG_W{1'b1}};
         ovf_d = 1'b1;
      end else begin
         mag_d = acc_d[MAG_W-1:0];
         ovf_d = 1'b0;
      end
      // A zero magnitude never carries a negative sign.
      sign_d = word_q[BCD_W-1] & (mag_d != {MAG_W{1'b0}});
   end

   // Control FSM with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         word_q    <= {BCD_W{1'b0}};
         acc_q     <= {ACC_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         bin_q     <= {(MAG_W+1){1'b0}};
         bin_vld_q <= 1'b0;
         bin_err_q <= 1'b0;
         bin_ovf_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               bin_vld_q <= 1'b0;
               if (bus.bcd_vld) begin
                  word_q  <= bus.bcd;
                  err_q   <= has_bad_digit(bus.bcd);
                  acc_q   <= {ACC_W{1'b0}};
                  cnt_q   <= CNT_TOP;
                  busy_q  <= 1'b1;
                  state_q <= S_ACC;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ACC: begin
               acc_q <= acc_d;
               if (cnt_q == {CNT_W{1'b0}}) begin
                  bin_q     <= {sign_d, mag_d};
                  bin_err_q <= err_q;
                  bin_ovf_q <= ovf_d;
                  bin_vld_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q   <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                  state_q <= S_ACC;
               end
            end
            S_DONE: begin
               bin_vld_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               bin_vld_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.bin     = bin_q;
   assign bus.bin_vld = bin_vld_q;
   assign bus.bin_err = bin_err_q;
   assign bus.bin_ovf = bin_ovf_q;

endmodule
